// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch (I) and load/store (D) requests onto one SRAM-like port.
// Optional ARB_TIMEOUT_EN adds a watchdog that aborts hung transactions and sets a sticky err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_resp,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq,
  output logic                err
);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_gnt_q, last_gnt_d;
  logic i_mask_q, d_mask_q;
  logic mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic i_pend, d_pend, to_hit;
  logic [DATA_W-1:0] rdata;
  // gnt/last_gnt: 1 = D, 0 = I; a requester just answered is masked for one IDLE cycle
  assign i_pend = i_req & ~i_mask_q;
  assign d_pend = d_req & ~d_mask_q;
  assign rdata = to_hit ? '0 : mem_rdata;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_gnt_d = last_gnt_q;
    mem_req_d = mem_req_q;
    mem_wr_d = mem_wr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d = 1'b0;
    d_resp_d = 1'b0;
    case (state_q)
      IDLE: if (i_pend | d_pend) begin
        gnt_d = d_pend & (~i_pend | ~last_gnt_q);
        last_gnt_d = gnt_d;
        mem_req_d = 1'b1;
        mem_wr_d = gnt_d & (|d_wen);
        mem_wstrb_d = gnt_d ? d_wen : '0;
        mem_addr_d = gnt_d ? d_addr : i_addr;
        mem_wdata_d = gnt_d ? d_wdata : '0;
        state_d = ADDR;
      end
      ADDR: if (to_hit | mem_addr_ok) begin
        mem_req_d = 1'b0;
        state_d = to_hit ? RESP : WAIT;
      end
      WAIT: if (to_hit | mem_data_ok) state_d = RESP;
      default: state_d = IDLE;
    endcase
    if (state_q != RESP && state_d == RESP) begin
      i_resp_d = ~gnt_q;
      d_resp_d = gnt_q;
      i_rdata_d = gnt_q ? i_rdata_q : rdata;
      d_rdata_d = (gnt_q & ~mem_wr_q) ? rdata : d_rdata_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      last_gnt_q <= 1'b0;
      i_mask_q <= 1'b0;
      d_mask_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_gnt_q <= last_gnt_d;
      i_mask_q <= i_resp_q;
      d_mask_q <= d_resp_q;
      mem_req_q <= mem_req_d;
      mem_wr_q <= mem_wr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q <= i_resp_d;
      d_resp_q <= d_resp_d;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign to_hit = (state_q == ADDR || state_q == WAIT) && cnt_q >= 16'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d = (state_d == state_q && (state_q == ADDR || state_q == WAIT)) ? cnt_q + 16'd1 : '0;
    err_d = err_q | to_hit;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  // no watchdog: the comparison is constant false, so the FSM waits indefinitely
  assign to_hit = TIMEOUT_CYCLES < 0;
  assign err = 1'b0;
`endif
  assign mem_req = mem_req_q;
  assign mem_wr = mem_wr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_resp = i_resp_q;
  assign d_resp = d_resp_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stallreq = (i_req & ~i_resp_q) | (d_req & ~d_resp_q);
endmodule
